// File: rtl/stepper_channels.sv
// NUM_CH independent step/dir generators: acceleration-limited velocity, phase-accumulator stepping, shared enable.
// Define STEPPER_RAMP_EN for the acceleration ramp; otherwise cur_vel follows the effective target one clock later.
module stepper_channels #(
  parameter int NUM_CH        = 2,
  parameter int SPEED_W       = 10,
  parameter int PHASE_W       = 24,
  parameter int PULSE_CYC     = 200,
  parameter int DIR_SETUP_CYC = 50,
  parameter int RAMP_DIV      = 1000,
  parameter int ACCEL_STEP    = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run_en,
  input  logic [NUM_CH*(SPEED_W+1)-1:0] target_vel,
  output logic [NUM_CH-1:0]             step,
  output logic [NUM_CH-1:0]             dir,
  output logic                          en_n,
  output logic [NUM_CH*(SPEED_W+1)-1:0] cur_vel,
  output logic [NUM_CH-1:0]             overrun
);
  localparam int VW      = SPEED_W + 1;
  localparam int SUM_W   = PHASE_W + VW;
  localparam int CNT_MAX = (PULSE_CYC > DIR_SETUP_CYC) ? PULSE_CYC : DIR_SETUP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic signed [VW-1:0] V_MIN   = {1'b1, {SPEED_W{1'b0}}};
  localparam logic signed [VW-1:0] V_CLAMP = {1'b1, {(SPEED_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_DIR_SETUP, S_PULSE, S_LOW} state_t;

  logic [NUM_CH-1:0] ch_quiet;

`ifdef STEPPER_RAMP_EN
  localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_DIV - 1);
  localparam logic signed [VW-1:0] ACC_V = VW'(ACCEL_STEP);
  localparam logic signed [VW:0]   ACC_D = (VW+1)'(ACCEL_STEP);

  logic [RC_W-1:0] ramp_cnt;
  logic            ramp_tick;

  assign ramp_tick = (ramp_cnt == RC_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ramp_cnt <= '0;
    else       ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic signed [VW-1:0] tgt, eff, vel, vel_n, vel_abs;
    logic [PHASE_W-1:0]   phase;
    logic [SUM_W-1:0]     sum;
    logic                 carry, pending, dir_r, dir_n, start, decide, step_r, ovr;
    logic [CNT_W-1:0]     cnt, cnt_n;
    state_t               state, state_n;

    assign tgt     = target_vel[i*VW +: VW];
    assign eff     = !run_en ? '0 : (tgt == V_MIN) ? V_CLAMP : tgt;
    assign vel_abs = vel[VW-1] ? -vel : vel;
    assign sum     = SUM_W'(phase) + SUM_W'(vel_abs);
    // Any overflow past PHASE_W counts as a single step request.
    assign carry   = |sum[SUM_W-1:PHASE_W];

`ifdef STEPPER_RAMP_EN
    logic signed [VW:0] diff;
    assign diff = {eff[VW-1], eff} - {vel[VW-1], vel};

    always_comb begin
      vel_n = vel;
      if (ramp_tick) begin
        if (diff > ACC_D)       vel_n = vel + ACC_V;
        else if (diff < -ACC_D) vel_n = vel - ACC_V;
        else                    vel_n = eff;
      end
    end
`else
    assign vel_n = eff;
`endif

    // The last LOW clock makes the same decision as IDLE so back-to-back steps keep a 2*PULSE_CYC period.
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dir_n   = dir_r;
      start   = 1'b0;
      decide  = 1'b0;
      case (state)
        S_DIR_SETUP: begin
          if (cnt == SETUP_LAST) begin state_n = S_IDLE; cnt_n = '0; end
          else cnt_n = cnt + 1'b1;
        end
        S_PULSE: begin
          if (cnt == PULSE_LAST) begin state_n = S_LOW; cnt_n = '0; end
          else cnt_n = cnt + 1'b1;
        end
        S_LOW: begin
          if (cnt == PULSE_LAST) begin state_n = S_IDLE; cnt_n = '0; decide = 1'b1; end
          else cnt_n = cnt + 1'b1;
        end
        default: decide = 1'b1;
      endcase
      if (decide) begin
        if (vel != '0 && dir_r == vel[VW-1]) begin
          dir_n   = ~vel[VW-1];
          state_n = S_DIR_SETUP;
          cnt_n   = '0;
        end else if (pending || carry) begin
          start   = 1'b1;
          state_n = S_PULSE;
          cnt_n   = '0;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state   <= S_IDLE;
        cnt     <= '0;
        dir_r   <= 1'b1;
        step_r  <= 1'b0;
        vel     <= '0;
        phase   <= '0;
        pending <= 1'b0;
        ovr     <= 1'b0;
      end else begin
        state  <= state_n;
        cnt    <= cnt_n;
        dir_r  <= dir_n;
        step_r <= (state_n == S_PULSE);
        vel    <= vel_n;
        phase  <= sum[PHASE_W-1:0];
        if (start && pending) begin
          pending <= carry;
        end else if (carry && !start) begin
          if (pending) ovr     <= 1'b1;
          else         pending <= 1'b1;
        end
      end
    end

    assign step[i]               = step_r;
    assign dir[i]                = dir_r;
    assign overrun[i]            = ovr;
    assign cur_vel[i*VW +: VW]   = vel;
    assign ch_quiet[i]           = (state == S_IDLE) && !pending && (vel == '0);
  end

  // Drivers stay enabled until every channel has stopped and finished its last pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          en_n <= 1'b1;
    else if (run_en)    en_n <= 1'b0;
    else if (&ch_quiet) en_n <= 1'b1;
  end
endmodule
